// File: rtl/acc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// acc_pkg : shared FSM encoding, ICB widths and defaults for the writeback path
// Rev 1.0
// ----------------------------------------------------------------------------
package acc_pkg;

  localparam int ICB_AW         = 32;
  localparam int ICB_DW         = 32;
  localparam int ICB_MW         = ICB_DW / 8;
  localparam int LEN_W          = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_MAX_OUTS   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } acc_state_e;

  // Byte address of result word idx; wraps modulo 2^32.
  function automatic logic [ICB_AW-1:0] word_addr(input logic [ICB_AW-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + {{(ICB_AW-LEN_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icb_wb_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// icb_wb_master_if : ICB command/response channel bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface icb_wb_master_if;
  import acc_pkg::*;

  logic              icb_cmd_valid;
  logic              icb_cmd_ready;
  logic              icb_cmd_read;
  logic [ICB_AW-1:0] icb_cmd_addr;
  logic [ICB_DW-1:0] icb_cmd_wdata;
  logic [ICB_MW-1:0] icb_cmd_wmask;
  logic              icb_rsp_valid;
  logic              icb_rsp_ready;
  logic [ICB_DW-1:0] icb_rsp_rdata;
  logic              icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with show-ahead head word and full/empty flags
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              push_i,
  input  wire [WIDTH-1:0]  wdata_i,
  input  wire              pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             w_push, w_pop;

  assign full_o  = (cnt_q == C_DEPTH);
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A push at full is legal when the head leaves in the same cycle.
  assign w_push = push_i && (!full_o || pop_i);
  assign w_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_push && !w_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!w_push && w_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/icb_wb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// icb_wb_master : buffers accelerator result words and writes them out over ICB
// Rev 1.0
// ----------------------------------------------------------------------------
module icb_wb_master
  import acc_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_OUTS   = DEF_MAX_OUTS
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               start,
  input  wire [ICB_AW-1:0]  base_addr,
  input  wire [LEN_W-1:0]   len,
  input  wire               in_valid,
  input  wire [ICB_DW-1:0]  in_data,
  output logic              in_ready,
  icb_wb_master_if.master   icb,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(MAX_OUTS + 1);
  localparam logic [CW-1:0] C_MAX_OUTS = CW'(MAX_OUTS);

  logic [1:0]        state_q, state_d;
  logic [ICB_AW-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  iss_q, iss_d;
  logic [CW-1:0]     outs_q, outs_d;
  logic              err_q, err_d;

  logic              w_fifo_full, w_fifo_empty;
  logic [ICB_DW-1:0] w_fifo_head;
  logic              w_start_acc, w_push, w_cmd_valid, w_cmd_hs, w_rsp_hs, w_rsp_dec;
  logic              w_unused_rdata;

  assign w_start_acc = start && (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_RUN) && !w_fifo_full && (acc_q < len_q);
  assign w_push      = in_valid && in_ready;

  // Valid only falls through a pop, so the head and address stay put while stalled.
  assign w_cmd_valid = (state_q == ST_RUN) && !w_fifo_empty && (outs_q < C_MAX_OUTS);
  assign w_cmd_hs    = w_cmd_valid && icb.icb_cmd_ready;
  assign w_rsp_hs    = icb.icb_rsp_valid && icb.icb_rsp_ready;
  assign w_rsp_dec   = w_rsp_hs && (outs_q != '0);

  assign icb.icb_cmd_valid = w_cmd_valid;
  assign icb.icb_cmd_read  = 1'b0;
  assign icb.icb_cmd_wmask = {ICB_MW{1'b1}};
  assign icb.icb_cmd_addr  = word_addr(base_q, iss_q);
  assign icb.icb_cmd_wdata = w_cmd_valid ? w_fifo_head : '0;
  assign icb.icb_rsp_ready = !rst;
  assign w_unused_rdata    = ^icb.icb_rsp_rdata;

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ICB_DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (in_data),
    .pop_i   (w_cmd_hs),
    .rdata_o (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    acc_d   = acc_q;
    iss_d   = iss_q;
    outs_d  = outs_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = len;
          acc_d   = '0;
          iss_d   = '0;
          outs_d  = '0;
          err_d   = 1'b0;
          state_d = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + LEN_W'(w_push);
        iss_d = iss_q + LEN_W'(w_cmd_hs);
        if (w_cmd_hs && !w_rsp_dec)      outs_d = outs_q + CW'(1);
        else if (!w_cmd_hs && w_rsp_dec) outs_d = outs_q - CW'(1);
        // Completion looks at this cycle's updated counts.
        if ((iss_d == len_q) && (outs_d == '0)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (w_rsp_hs && icb.icb_rsp_err && !w_start_acc) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      iss_q   <= '0;
      outs_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      iss_q   <= iss_d;
      outs_q  <= outs_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icb_wb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_icb_wb_master : randomized self-checking bench with a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_icb_wb_master;
  import acc_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done, err;

  icb_wb_master_if bus ();

  icb_wb_master #(.FIFO_DEPTH(DEPTH), .MAX_OUTS(MAXO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .icb(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int fails = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: job phase 0 idle / 1 running / 2 done pulse, plus word counts.
  int          ph, m_len, m_acc, m_iss, m_outs, m_occ;
  logic [31:0] m_base;
  bit          m_err;
  logic [31:0] jd[$];
  logic [31:0] addr_log[$];
  int          send_idx, rsp_idx, err_at;
  int          p_valid, p_ready, p_rsp, hold_cmd_until, rsp_mode, cyc;
  int          done_cnt, cmd_cnt;
  bit          prev_stall;
  logic [31:0] prev_addr, prev_wdata;

  task automatic model_clear();
    ph = 0; m_len = 0; m_acc = 0; m_iss = 0; m_outs = 0; m_occ = 0;
    m_base = '0; m_err = 1'b0; send_idx = 0; rsp_idx = 0; prev_stall = 1'b0;
    jd.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk_val({pfx, "_in_ready"},  in_ready, 0);
    chk_val({pfx, "_cmd_valid"}, bus.icb_cmd_valid, 0);
    chk_val({pfx, "_rsp_ready"}, bus.icb_rsp_ready, 0);
    chk_val({pfx, "_busy"},      busy, 0);
    chk_val({pfx, "_done"},      done, 0);
    chk_val({pfx, "_err"},       err, 0);
    chk_val({pfx, "_addr"},      bus.icb_cmd_addr, 0);
    chk_val({pfx, "_wdata"},     bus.icb_cmd_wdata, 0);
    chk_val({pfx, "_wmask"},     bus.icb_cmd_wmask, 4'hF);
    chk_val({pfx, "_read"},      bus.icb_cmd_read, 0);
  endtask

  // One clock: drive just after negedge, observe 1ns later, advance model.
  task automatic step(input bit do_start);
    bit allow, push, pop, rsp;
    start = do_start;
    in_valid = (send_idx < jd.size()) && ($urandom_range(99) < p_valid);
    if (in_valid) in_data = jd[send_idx];
    else          in_data = $urandom;
    bus.icb_cmd_ready = (cyc >= hold_cmd_until) && ($urandom_range(99) < p_ready);
    allow = (rsp_mode == 0) || (cyc == 15) || (cyc >= 25);
    bus.icb_rsp_valid = allow && (m_outs > 0) && ($urandom_range(99) < p_rsp);
    bus.icb_rsp_err   = bus.icb_rsp_valid && (rsp_idx == err_at);
    bus.icb_rsp_rdata = $urandom;
    #1;
    chk_val("busy", busy, ph != 0);
    chk_val("done", done, ph == 2);
    chk_val("err", err, m_err);
    chk_val("in_ready", in_ready, (ph == 1) && (m_occ < DEPTH) && (m_acc < m_len));
    chk_val("cmd_valid", bus.icb_cmd_valid, (ph == 1) && (m_occ > 0) && (m_outs < MAXO));
    chk_val("rsp_ready", bus.icb_rsp_ready, 1);
    if (prev_stall) begin
      chk_val("stall_addr", bus.icb_cmd_addr, prev_addr);
      chk_val("stall_wdata", bus.icb_cmd_wdata, prev_wdata);
    end
    push = in_valid && in_ready;
    pop  = bus.icb_cmd_valid && bus.icb_cmd_ready;
    rsp  = bus.icb_rsp_valid && bus.icb_rsp_ready;
    if (pop) begin
      chk_val("wr_addr", bus.icb_cmd_addr, m_base + 32'(m_iss) * 32'd4);
      chk_val("wr_in_range", m_iss < jd.size(), 1);
      if (m_iss < jd.size()) chk_val("wr_data", bus.icb_cmd_wdata, jd[m_iss]);
      chk_val("wr_read", bus.icb_cmd_read, 0);
      chk_val("wr_mask", bus.icb_cmd_wmask, 4'hF);
      addr_log.push_back(bus.icb_cmd_addr);
      cmd_cnt++;
    end
    prev_stall = bus.icb_cmd_valid && !bus.icb_cmd_ready;
    prev_addr  = bus.icb_cmd_addr;
    prev_wdata = bus.icb_cmd_wdata;
    if (done) done_cnt++;
    if (push) send_idx++;
    m_acc  += int'(push);
    m_occ  += int'(push) - int'(pop);
    m_iss  += int'(pop);
    m_outs += int'(pop) - int'(rsp);
    if (rsp) begin
      if (bus.icb_rsp_err) m_err = 1'b1;
      rsp_idx++;
    end
    case (ph)
      0: if (do_start) begin
        m_base = base_addr; m_len = int'(len);
        m_acc = 0; m_iss = 0; m_outs = 0; m_occ = 0; m_err = 1'b0;
        ph = (len == 16'd0) ? 2 : 1;
      end
      1: if ((m_iss == m_len) && (m_outs == 0)) ph = 2;
      default: ph = 0;
    endcase
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    bus.icb_cmd_ready = 1'b0; bus.icb_rsp_valid = 1'b0; bus.icb_rsp_err = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    #1;
    chk_val("rst_hold_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run_job(input logic [31:0] b, input int n, input int max_cyc);
    base_addr = b; len = 16'(n);
    cyc = 0; send_idx = 0; rsp_idx = 0; done_cnt = 0; cmd_cnt = 0;
    addr_log.delete();
    step(1'b1);
    while (ph != 0 && cyc < max_cyc) begin
      step(1'b0);
      if (rsp_mode == 1 && cyc == 15) chk_val("outs_cap_issued", m_iss, 4);
      if (rsp_mode == 1 && cyc == 25) chk_val("one_rsp_one_cmd", m_iss, 5);
      if (hold_cmd_until == 20 && cyc == 20) chk_val("accepted_at_stall", m_acc, DEPTH);
    end
    chk_val("job_end_phase", ph, 0);
    chk_val("done_pulses", done_cnt, 1);
    chk_val("cmd_count", cmd_cnt, n);
    if (ph != 0) apply_reset();
    step(1'b0);
  endtask

  task automatic fill_data(input int n);
    jd.delete();
    for (int i = 0; i < n; i++) jd.push_back($urandom);
  endtask

  task automatic knobs(input int pv, input int pr, input int ps);
    p_valid = pv; p_ready = pr; p_rsp = ps;
    hold_cmd_until = 0; rsp_mode = 0; err_at = -1;
  endtask

  logic [31:0] wrap_exp [4];

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0; in_data = '0;
    bus.icb_cmd_ready = 1'b0; bus.icb_rsp_valid = 1'b0; bus.icb_rsp_err = 1'b0;
    bus.icb_rsp_rdata = '0;
    model_clear();
    knobs(100, 100, 100);
    cyc = 0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(1'b0);

    // Basic four-word job, everything immediate.
    jd.delete();
    jd.push_back(32'h11); jd.push_back(32'h22); jd.push_back(32'h33); jd.push_back(32'h44);
    run_job(32'h2000_0000, 4, 200);
    chk_val("basic_err", err, 0);

    // Command channel stalled for 20 cycles; FIFO fills to its depth.
    knobs(100, 100, 100);
    hold_cmd_until = 20;
    fill_data(12);
    run_job(32'h1000_0100, 12, 400);

    // Responses withheld: outstanding cap, then one response frees one command.
    knobs(100, 100, 100);
    rsp_mode = 1;
    fill_data(8);
    run_job(32'h3000_0000, 8, 400);

    // Address wrap-around past 0xFFFF_FFFC.
    knobs(100, 100, 100);
    fill_data(4);
    run_job(32'hFFFF_FFF8, 4, 200);
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;
    chk_val("wrap_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk_val("wrap_addr", addr_log[i], wrap_exp[i]);

    // Error on the second response; job still completes, err sticky.
    knobs(100, 100, 100);
    err_at = 1;
    fill_data(6);
    run_job(32'h4000_0000, 6, 300);
    chk_val("err_sticky", err, 1);

    // Next start clears err.
    knobs(80, 80, 80);
    fill_data(3);
    run_job(32'h4000_1000, 3, 300);
    chk_val("err_cleared", err, 0);

    // Zero-length job.
    knobs(100, 100, 100);
    jd.delete();
    run_job(32'h5000_0000, 0, 20);

    // Reset mid-job with three words buffered.
    knobs(100, 100, 100);
    hold_cmd_until = 1000;
    fill_data(8);
    base_addr = 32'h6000_0000; len = 16'd8;
    cyc = 0; send_idx = 0; rsp_idx = 0; done_cnt = 0; cmd_cnt = 0;
    step(1'b1);
    while (m_occ < 3 && cyc < 20) step(1'b0);
    chk_val("pre_rst_buffered", m_occ, 3);
    apply_reset();
    knobs(100, 100, 100);
    done_cnt = 0;
    repeat (4) step(1'b0);
    chk_val("post_rst_no_done", done_cnt, 0);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      int n;
      knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30));
      n = $urandom_range(20, 1);
      if ($urandom_range(3) == 0) err_at = $urandom_range(n - 1, 0);
      fill_data(n);
      run_job($urandom & 32'hFFFF_FFFC, n, 2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icb_wb_master.md
ICB_WB_MASTER -- requirements
Module: icb_wb_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning result-buffer depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTS, default 4, meaning maximum ICB write commands issued but not yet responded.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port start  input  1  single-cycle pulse launching a writeback job.
REQ-007 Port base_addr  input  32  system byte address of the first result word, sampled at accepted start.
REQ-008 Port len  input  16  number of 32-bit words in the job, sampled at accepted start.
REQ-009 Port in_valid  input  1  accelerator result word valid.
REQ-010 Port in_data  input  32  accelerator result word.
REQ-011 Port in_ready  output  1  block accepts in_data this cycle.
REQ-012 Ports icb_cmd_valid out 1, icb_cmd_ready in 1, icb_cmd_read out 1, icb_cmd_addr out 32, icb_cmd_wdata out 32, icb_cmd_wmask out 4: ICB command channel, master side.
REQ-013 Ports icb_rsp_valid in 1, icb_rsp_ready out 1, icb_rsp_rdata in 32 (ignored), icb_rsp_err in 1: ICB response channel, master side.
REQ-014 Ports busy out 1, done out 1 (one-cycle pulse), err out 1 (sticky per job).

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; start accepted only in IDLE, ignored otherwise.
REQ-016 Accepted start with len!=0 -> RUN next cycle; latch base_addr/len; clear accepted, issued and outstanding counts and err.
REQ-017 Accepted start with len==0 -> DONE next cycle; no ICB command is issued.
REQ-018 in_ready SHALL be 1 only in RUN, FIFO not full, and accepted<len; a word is pushed on in_valid&in_ready.
REQ-019 icb_cmd_valid SHALL be 1 in RUN when FIFO non-empty and outstanding<MAX_OUTS; payload is the FIFO head.
REQ-020 icb_cmd_addr = latched base + 4*issued, 32-bit wrap-around; icb_cmd_read=0; icb_cmd_wmask=4'hF.
REQ-021 Once asserted, icb_cmd_valid and its payload SHALL hold stable until icb_cmd_ready; handshake pops FIFO, increments issued and outstanding.
REQ-022 icb_rsp_ready SHALL be 1 whenever not in reset; each icb_rsp_valid decrements outstanding; icb_rsp_err=1 sets err.
REQ-023 Simultaneous command handshake and response in one cycle SHALL leave outstanding unchanged.
REQ-024 Push and pop in the same cycle SHALL leave FIFO occupancy unchanged, including at full and empty.
REQ-025 RUN -> DONE when issued==len and outstanding==0 (sampled after that cycle's updates); DONE lasts one cycle, done=1, then IDLE.
REQ-026 Errors SHALL NOT abort the job; all len words are still written.
REQ-027 busy SHALL be 1 in RUN and DONE; err holds until next accepted start.
REQ-028 Minimum latency: in_valid word accepted at cycle N appears on icb_cmd_valid at cycle N+1.

Reset
REQ-029 On rst: state IDLE, FIFO empty, all counters 0; in_ready, icb_cmd_valid, icb_rsp_ready, busy, done, err all 0; icb_cmd_addr/wdata 0; icb_cmd_wmask 4'hF; icb_cmd_read 0.
REQ-030 Reset mid-job SHALL drop buffered data and pending commands without pulsing done.

Structure
REQ-031 Shared package acc_pkg SHALL hold the FSM state enum, ICB width constants and default FIFO_DEPTH/MAX_OUTS.
REQ-032 FIFO SHALL be a separate sub-module sync_fifo (parameterized depth/width, full/empty flags).

Verification
REQ-033 base=0x2000_0000, len=4, words 0x11..0x44, ready and responses immediate -> writes to 0x2000_0000/04/08/0C with those data, done one pulse, err=0.
REQ-034 len=12, icb_cmd_ready held 0 for 20 cycles -> in_ready drops after 8 accepted words; payload stable; all 12 written in order after release.
REQ-035 Responses withheld -> exactly 4 commands issued then icb_cmd_valid low; one response releases exactly one more command.
REQ-036 base=0xFFFF_FFF8, len=4 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
REQ-037 Second response carries icb_rsp_err=1 -> err=1 through done, remaining words still written; next start clears err.
REQ-038 len=0 -> done one cycle after start, no command; rst asserted mid-job with 3 words buffered -> all outputs reset values, no done pulse.
